// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus responder.
// Optional feature macro used by the responder: MEM_BUS_RESPONDER_PENDING_EN.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ACK  = 2'd2
  } mem_state_e;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  localparam int MEM_DEPTH_DEFAULT   = 256;
  localparam int MEM_LATENCY_DEFAULT = 1;

  // True when a word address falls outside the implemented array.
  function automatic logic addr_oob(input logic [31:0] addr, input int unsigned depth);
    return {1'b0, addr} >= 33'(depth);
  endfunction

endpackage

// File: rtl/mem_bus_array.sv
// Single-port word storage: synchronous write, registered read data.
// The read register doubles as the responder's mem_rd_data hold register.
module mem_bus_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          we,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Storage contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read data only moves on a read or an out-of-range access; writes leave it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          rdata <= '0;
    else if (clr)        rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory bus responder: accepts one-cycle request pulses, waits LATENCY
// cycles, then pulses mem_ack with read data / error status.
// Optional one-entry pending buffer: MEM_BUS_RESPONDER_PENDING_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// MEM_IDLE | no transaction in flight
// MEM_WAIT | latency down-counter running for the captured request
// MEM_ACK  | mem_ack high this cycle; may start the next request
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH   = MEM_DEPTH_DEFAULT,
  parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_valid,
  input  logic        mem_rd_wr,
  input  logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] mem_rd_data,
  output logic        mem_ack,
  output logic        mem_err,
  output logic        mem_busy,
  output logic        mem_overrun
);

  localparam int         AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);

  mem_state_e  state;
  logic [3:0]  cnt;
  logic        cur_rw;
  logic [31:0] cur_addr, cur_data;
`ifdef MEM_BUS_RESPONDER_PENDING_EN
  logic        pend_vld, pend_rw;
  logic [31:0] pend_addr, pend_data;
  logic        to_pend;
`endif
  logic [31:0] req_addr;
  logic        st_go, st_rw, lost;
  logic [31:0] st_addr, st_data;
  logic        iss, iss_rw, iss_err;
  logic [31:0] iss_addr, iss_data;

  assign req_addr = (mem_rd_wr == MEM_WR) ? mem_wr_addr : mem_rd_addr;

  // Decide which request (if any) becomes the current transaction, and which are lost.
  always_comb begin
    st_go   = 1'b0;
    st_rw   = mem_rd_wr;
    st_addr = req_addr;
    st_data = mem_wr_data;
    lost    = 1'b0;
`ifdef MEM_BUS_RESPONDER_PENDING_EN
    to_pend = 1'b0;
`endif
    case (state)
      MEM_IDLE: st_go = mem_req_valid;
      MEM_WAIT: begin
`ifdef MEM_BUS_RESPONDER_PENDING_EN
        if (mem_req_valid) begin
          if (pend_vld) lost    = 1'b1;
          else          to_pend = 1'b1;
        end
`else
        lost = mem_req_valid;
`endif
      end
      MEM_ACK: begin
`ifdef MEM_BUS_RESPONDER_PENDING_EN
        // Pending entry goes first; a fresh request refills the freed slot.
        if (pend_vld) begin
          st_go   = 1'b1;
          st_rw   = pend_rw;
          st_addr = pend_addr;
          st_data = pend_data;
          to_pend = mem_req_valid;
        end else begin
          st_go = mem_req_valid;
        end
`else
        st_go = mem_req_valid;
`endif
      end
      default: ;
    endcase
  end

  // Array access happens on the edge that enters ACK.
  always_comb begin
    iss      = 1'b0;
    iss_rw   = cur_rw;
    iss_addr = cur_addr;
    iss_data = cur_data;
    if (state == MEM_WAIT && cnt <= 4'd1) begin
      iss = 1'b1;
    end else if (st_go && LATENCY == 0) begin
      iss      = 1'b1;
      iss_rw   = st_rw;
      iss_addr = st_addr;
      iss_data = st_data;
    end
  end

  assign iss_err = addr_oob(iss_addr, DEPTH);

  mem_bus_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (iss && !iss_err),
    .we    (iss_rw == MEM_WR),
    .clr   (iss && iss_err),
    .addr  (iss_addr[AW-1:0]),
    .wdata (iss_data),
    .rdata (mem_rd_data)
  );

  // Sequencing FSM with registered ack/err/busy/overrun outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= MEM_IDLE;
      cnt         <= '0;
      cur_rw      <= MEM_RD;
      cur_addr    <= '0;
      cur_data    <= '0;
      mem_ack     <= 1'b0;
      mem_err     <= 1'b0;
      mem_busy    <= 1'b0;
      mem_overrun <= 1'b0;
`ifdef MEM_BUS_RESPONDER_PENDING_EN
      pend_vld    <= 1'b0;
      pend_rw     <= MEM_RD;
      pend_addr   <= '0;
      pend_data   <= '0;
`endif
    end else begin
      mem_ack <= iss;
      mem_err <= iss && iss_err;
      if (lost) mem_overrun <= 1'b1;
`ifdef MEM_BUS_RESPONDER_PENDING_EN
      if (to_pend) begin
        pend_vld  <= 1'b1;
        pend_rw   <= mem_rd_wr;
        pend_addr <= req_addr;
        pend_data <= mem_wr_data;
      end else if (state == MEM_ACK) begin
        pend_vld  <= 1'b0;
      end
`endif
      if (st_go) begin
        cur_rw   <= st_rw;
        cur_addr <= st_addr;
        cur_data <= st_data;
        mem_busy <= 1'b1;
        if (LATENCY == 0) begin
          state <= MEM_ACK;
        end else begin
          state <= MEM_WAIT;
          cnt   <= LAT;
        end
      end else if (state == MEM_WAIT) begin
        mem_busy <= 1'b1;
        if (cnt <= 4'd1) begin
          state <= MEM_ACK;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end else begin
        state    <= MEM_IDLE;
        mem_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: three responder instances (LATENCY 0, 1, 3) share stimulus;
// each test resets all of them and checks the instance it targets.
module tb_mem_bus_responder;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0, rw = 1'b0;
  logic [31:0] ra = '0, wa = '0, wd = '0;

  logic [31:0] rd0, rd1, rd3;
  logic        ack0, err0, busy0, ovr0;
  logic        ack1, err1, busy1, ovr1;
  logic        ack3, err3, busy3, ovr3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.DEPTH(256), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .mem_req_valid(valid), .mem_rd_wr(rw),
    .mem_rd_addr(ra), .mem_wr_addr(wa), .mem_wr_data(wd),
    .mem_rd_data(rd0), .mem_ack(ack0), .mem_err(err0), .mem_busy(busy0), .mem_overrun(ovr0));
  mem_bus_responder #(.DEPTH(256), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .mem_req_valid(valid), .mem_rd_wr(rw),
    .mem_rd_addr(ra), .mem_wr_addr(wa), .mem_wr_data(wd),
    .mem_rd_data(rd1), .mem_ack(ack1), .mem_err(err1), .mem_busy(busy1), .mem_overrun(ovr1));
  mem_bus_responder #(.DEPTH(256), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .mem_req_valid(valid), .mem_rd_wr(rw),
    .mem_rd_addr(ra), .mem_wr_addr(wa), .mem_wr_data(wd),
    .mem_rd_data(rd3), .mem_ack(ack3), .mem_err(err3), .mem_busy(busy3), .mem_overrun(ovr3));

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic rd_req(input logic [31:0] addr);
    valid = 1'b1; rw = MEM_RD; ra = addr; wa = 32'h0; wd = 32'h0;
  endtask

  task automatic wr_req(input logic [31:0] addr, input logic [31:0] data);
    valid = 1'b1; rw = MEM_WR; ra = 32'h0; wa = addr; wd = data;
  endtask

  task automatic no_req();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    no_req();
    nxt();
    reset = 1'b0;
    repeat (2) nxt();
    reset = 1'b1;
    nxt();
  endtask

  task automatic test_reset();
    no_req();
    reset = 1'b0;
    repeat (2) nxt();
    checks++; if (ack1 !== 1'b0)  begin errors++; $display("FAIL reset_ack got=%b exp=0", ack1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++; if (rd1 !== 32'h0)  begin errors++; $display("FAIL reset_rd got=%h exp=0", rd1); end
    checks++; if ({err1, ovr1} !== 2'b00) begin errors++; $display("FAIL reset_err_ovr got=%b exp=00", {err1, ovr1}); end
    reset = 1'b1;
    nxt();
  endtask

  task automatic test_write_read();
    do_reset();
    wr_req(32'd5, 32'hDEADBEEF);                       // cycle 0
    nxt(); no_req();
    checks++; if ({ack1, busy1} !== 2'b01) begin errors++; $display("FAIL wr_c1 ack,busy got=%b exp=01", {ack1, busy1}); end
    nxt();
    checks++; if ({ack1, err1} !== 2'b10) begin errors++; $display("FAIL wr_ack ack,err got=%b exp=10", {ack1, err1}); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL wr_rd_unchanged got=%h exp=0", rd1); end
    rd_req(32'd5);                                     // back-to-back from ACK
    nxt(); no_req();
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rd_c1 ack got=%b exp=0", ack1); end
    nxt();
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL rd_ack got=%b exp=1", ack1); end
    checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", rd1); end
    nxt();
    checks++; if ({ack1, busy1, ovr1} !== 3'b000) begin errors++; $display("FAIL wr_rd_end ack,busy,ovr got=%b exp=000", {ack1, busy1, ovr1}); end
  endtask

  task automatic test_latency0();
    do_reset();
    wr_req(32'd7, 32'h11111111);
    nxt();
    checks++; if ({ack0, err0} !== 2'b10) begin errors++; $display("FAIL l0_wr7 ack,err got=%b exp=10", {ack0, err0}); end
    wr_req(32'd8, 32'h22222222);
    nxt();
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL l0_wr8 ack got=%b exp=1", ack0); end
    rd_req(32'd7);
    nxt();
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL l0_rd7 ack got=%b exp=1", ack0); end
    checks++; if (rd0 !== 32'h11111111) begin errors++; $display("FAIL l0_rd7 data got=%h exp=11111111", rd0); end
    rd_req(32'd8);
    nxt(); no_req();
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL l0_rd8 ack got=%b exp=1", ack0); end
    checks++; if (rd0 !== 32'h22222222) begin errors++; $display("FAIL l0_rd8 data got=%h exp=22222222", rd0); end
    nxt();
    checks++; if ({ack0, busy0, ovr0} !== 3'b000) begin errors++; $display("FAIL l0_end ack,busy,ovr got=%b exp=000", {ack0, busy0, ovr0}); end
    checks++; if (rd0 !== 32'h22222222) begin errors++; $display("FAIL l0_hold data got=%h exp=22222222", rd0); end
  endtask

  task automatic test_addr_error();
    do_reset();
    wr_req(32'd44, 32'hA5A5A5A5);
    nxt(); no_req(); nxt();
    rd_req(32'd44);
    nxt(); no_req(); nxt();
    checks++; if (rd1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL err_pre data got=%h exp=a5a5a5a5", rd1); end
    rd_req(32'd300);
    nxt(); no_req(); nxt();
    checks++; if ({ack1, err1} !== 2'b11) begin errors++; $display("FAIL err_rd ack,err got=%b exp=11", {ack1, err1}); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL err_rd data got=%h exp=0", rd1); end
    wr_req(32'd300, 32'hFFFFFFFF);
    nxt(); no_req(); nxt();
    checks++; if ({ack1, err1} !== 2'b11) begin errors++; $display("FAIL err_wr ack,err got=%b exp=11", {ack1, err1}); end
    rd_req(32'd44);
    nxt(); no_req(); nxt();
    checks++; if ({ack1, err1} !== 2'b10) begin errors++; $display("FAIL err_rd44 ack,err got=%b exp=10", {ack1, err1}); end
    checks++; if (rd1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL err_rd44 data got=%h exp=a5a5a5a5", rd1); end
    checks++; if (ovr1 !== 1'b0) begin errors++; $display("FAIL err_ovr got=%b exp=0", ovr1); end
  endtask

  task automatic test_back_to_back_pending();
    logic [10:0] exp_ack;
`ifdef MEM_BUS_RESPONDER_PENDING_EN
    exp_ack = 11'b001_0001_0000;   // acks at cycles 4 and 8
`else
    exp_ack = 11'b000_0001_0000;   // ack at cycle 4 only
`endif
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c >= 1) begin
        checks++;
        if (ack3 !== exp_ack[c]) begin errors++; $display("FAIL pend_ack c=%0d got=%b exp=%b", c, ack3, exp_ack[c]); end
      end
      if (c == 4) begin
        checks++; if ({err3, rd3} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL pend_rd got=%b/%h exp=0/deadbeef", err3, rd3); end
      end
      if (c <= 2) rd_req(32'd5); else no_req();
      nxt();
    end
    checks++; if (ovr3 !== 1'b1) begin errors++; $display("FAIL pend_ovr got=%b exp=1", ovr3); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL pend_busy got=%b exp=0", busy3); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      if (c <= 2 || c == 5) rd_req(32'd5); else no_req();
      nxt();
    end
    no_req();                                           // cycle 6: u3 in WAIT
    checks++; if ({busy3, ovr3} !== 2'b11) begin errors++; $display("FAIL mid_pre busy,ovr got=%b exp=11", {busy3, ovr3}); end
    checks++; if (rd3 !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_pre data got=%h exp=deadbeef", rd3); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({ack3, err3, busy3, ovr3} !== 4'b0000) begin errors++; $display("FAIL mid_async flags got=%b exp=0000", {ack3, err3, busy3, ovr3}); end
    checks++; if (rd3 !== 32'h0) begin errors++; $display("FAIL mid_async data got=%h exp=0", rd3); end
    nxt();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      nxt();
      checks++; if (ack3 !== 1'b0) begin errors++; $display("FAIL mid_noack c=%0d got=%b exp=0", c, ack3); end
    end
    rd_req(32'd5);
    for (int c = 1; c <= 4; c++) begin
      nxt(); no_req();
      checks++;
      if (ack3 !== (c == 4)) begin errors++; $display("FAIL mid_next c=%0d got=%b exp=%b", c, ack3, (c == 4)); end
    end
    checks++; if (rd3 !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_next data got=%h exp=deadbeef", rd3); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency0();
    test_addr_error();
    test_back_to_back_pending();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
